addr_mode_seq: RTL and testbench
================================

# addr_mode_seq

Parametrised successor to the fixed address-mode state machine. It sequences the bus cycles of one 6502 instruction across all eight addressing-mode classes, using one-hot registered state outputs. It adds RDY stalling, a write-forced page-fix cycle and a per-instruction cycle counter. It sits between the opcode decoder (which supplies MODE, WR) and the address/data-path muxes (which consume the state strobes).

## Interface
- CROSS_ALWAYS, 1: when 1, indexed writes (WR=1) always take the CO fix cycle; when 0, CO is taken only on carry.
- CYC_W, 3: width of the CYC cycle counter.
- CLK  in  1  system clock, all state changes on rising edge.
- R  in  1  reset, asynchronous, active-low.
- RDY  in  1  memory ready; 0 freezes all state, MD and CYC.
- MODE  in  3  addressing class from decoder, valid in SOP: 0 IMP, 1 IMM, 2 ZP, 3 ZPX, 4 ABS, 5 ABSX, 6 INDY, 7 INDX.
- WR  in  1  instruction writes memory, valid in SOP.
- CI  in  1  carry-out of address low-byte adder, valid in SHI (ABSX) and SIH (INDY).
- S0  out  1  idle (post-reset only).
- SOP  out  1  opcode fetch (SYNC).
- SLO  out  1  operand low / zero-page byte fetch.
- SHI  out  1  operand high byte fetch.
- SIX  out  1  index-add dummy cycle.
- SIL  out  1  indirect pointer low read.
- SIH  out  1  indirect pointer high read.
- SCO  out  1  page-carry fix cycle.
- SLR  out  1  last (data read/write/execute) cycle.
- MD  out  3  mode latched at SOP.
- CYC  out  CYC_W  cycle index within instruction, 0 in SOP.

## Operation
- Exactly one of S0,SOP,SLO,SHI,SIX,SIL,SIH,SCO,SLR high at all times; all registered.
- Reset: S0=1, all other strobes 0, MD=0, CYC=0.
- S0 -> SOP unconditionally (when RDY=1).
- In SOP: latch MODE into MD, WR into internal wr_q; CYC:=0.
- Sequences (from SOP, by MODE):
  - IMP, IMM: SOP, SLR.
  - ZP: SOP, SLO, SLR.
  - ZPX: SOP, SLO, SIX, SLR.
  - ABS: SOP, SLO, SHI, SLR.
  - ABSX: SOP, SLO, SHI, [SCO], SLR.
  - INDY: SOP, SLO, SIL, SIH, [SCO], SLR.
  - INDX: SOP, SLO, SIX, SIL, SIH, SLR.
- [SCO] taken iff CI=1, or (CROSS_ALWAYS=1 and wr_q=1); CI sampled in SHI/SIH only.
- SLR -> SOP always (next instruction fetch); SCO -> SLR.
- Branching out of SOP uses live MODE; later transitions use MD.
- CYC increments on every advancing edge after SOP, saturating at 2^CYC_W-1.

## Timing
- One state per RDY=1 cycle; RDY=0 holds state, MD, CYC, wr_q; CI/MODE ignored while stalled.
- Instruction length (SOP to SLR inclusive, no stalls): IMP/IMM 2, ZP 3, ZPX 4, ABS 4, ABSX 4/5, INDY 5/6, INDX 6.
- First SOP appears on the first RDY=1 edge after R deasserts.
- R asserted mid-instruction: all outputs return to reset values immediately (asynchronous), independent of CLK.
- CI high in any state other than SHI/SIH: no effect.
- RDY=0 during SOP: MODE re-sampled when RDY returns.

## Test plan
- Reset then RDY=1, MODE=4: S0 for one cycle, then SOP, SLO, SHI, SLR, SOP; CYC 0,1,2,3,0; MD=4.
- MODE=5, CI=1 in SHI: SOP, SLO, SHI, SCO, SLR; CI=0 repeat: no SCO, 4 cycles.
- MODE=5, WR=1, CI=0: CROSS_ALWAYS=1 gives 5-cycle sequence with SCO; CROSS_ALWAYS=0 gives 4 cycles.
- MODE=6, RDY=0 for 3 cycles in SIL, CI=1 in SIH: SIL held 4 cycles, CYC frozen at 2, then SIH, SCO, SLR; total 9 cycles.
- MODE=7 then MODE=0 back-to-back: SOP, SLO, SIX, SIL, SIH, SLR, SOP, SLR, SOP; exactly one strobe high every cycle.
- R driven low mid-INDY in SIH between clock edges: S0=1, MD=0, CYC=0 at once; after release, SOP follows.

Source files
------------

// File: rtl/addr_mode_seq.sv
// Bus-cycle sequencer for one 6502 instruction across all eight addressing classes.
// One-hot registered state strobes, RDY stalling, optional forced page-fix on writes, cycle index.
module addr_mode_seq #(
    parameter bit          CROSS_ALWAYS = 1'b1,
    parameter int unsigned CYC_W        = 3
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             RDY,
    input  logic [2:0]       MODE,
    input  logic             WR,
    input  logic             CI,
    output logic             S0,
    output logic             SOP,
    output logic             SLO,
    output logic             SHI,
    output logic             SIX,
    output logic             SIL,
    output logic             SIH,
    output logic             SCO,
    output logic             SLR,
    output logic [2:0]       MD,
    output logic [CYC_W-1:0] CYC
);

    typedef enum logic [8:0] {
        StIdle = 9'b0_0000_0001,
        StOp   = 9'b0_0000_0010,
        StLo   = 9'b0_0000_0100,
        StHi   = 9'b0_0000_1000,
        StIx   = 9'b0_0001_0000,
        StIl   = 9'b0_0010_0000,
        StIh   = 9'b0_0100_0000,
        StCo   = 9'b0_1000_0000,
        StLr   = 9'b1_0000_0000
    } state_e;

    localparam logic [2:0] ModeImp  = 3'd0;
    localparam logic [2:0] ModeImm  = 3'd1;
    localparam logic [2:0] ModeZp   = 3'd2;
    localparam logic [2:0] ModeZpx  = 3'd3;
    localparam logic [2:0] ModeAbs  = 3'd4;
    localparam logic [2:0] ModeAbsx = 3'd5;
    localparam logic [2:0] ModeIndy = 3'd6;
    localparam logic [2:0] ModeIndx = 3'd7;

    state_e           state_q, state_d;
    logic [2:0]       md_q, md_d;
    logic             wr_q, wr_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             fix;

    // Writes may be forced through the fix cycle so the bus never writes a wrong page.
    assign fix = CI | (CROSS_ALWAYS & wr_q);

    always_comb begin
        state_d = state_q;
        md_d    = md_q;
        wr_d    = wr_q;
        cyc_d   = cyc_q;
        if (RDY) begin
            unique case (state_q)
                StIdle: state_d = StOp;
                StOp: begin
                    md_d    = MODE;
                    wr_d    = WR;
                    state_d = (MODE == ModeImp || MODE == ModeImm) ? StLr : StLo;
                end
                StLo: begin
                    case (md_q)
                        ModeZpx, ModeIndx:  state_d = StIx;
                        ModeAbs, ModeAbsx:  state_d = StHi;
                        ModeIndy:           state_d = StIl;
                        default:            state_d = StLr;
                    endcase
                end
                StHi:    state_d = (md_q == ModeAbsx && fix) ? StCo : StLr;
                StIx:    state_d = (md_q == ModeIndx) ? StIl : StLr;
                StIl:    state_d = StIh;
                StIh:    state_d = (md_q == ModeIndy && fix) ? StCo : StLr;
                StCo:    state_d = StLr;
                StLr:    state_d = StOp;
                default: state_d = StIdle;
            endcase
            if (state_d == StOp) begin
                cyc_d = '0;
            end else if (cyc_q != '1) begin
                cyc_d = cyc_q + CYC_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q <= StIdle;
            md_q    <= '0;
            wr_q    <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            md_q    <= md_d;
            wr_q    <= wr_d;
            cyc_q   <= cyc_d;
        end
    end

    assign S0  = state_q[0];
    assign SOP = state_q[1];
    assign SLO = state_q[2];
    assign SHI = state_q[3];
    assign SIX = state_q[4];
    assign SIL = state_q[5];
    assign SIH = state_q[6];
    assign SCO = state_q[7];
    assign SLR = state_q[8];
    assign MD  = md_q;
    assign CYC = cyc_q;

endmodule

// File: tb/tb_addr_mode_seq.sv
// Directed bench for addr_mode_seq: two instances (forced write fix on/off) driven from a
// vector table, plus a hand-written asynchronous reset sequence.
module tb_addr_mode_seq;

    localparam logic [8:0] P_S0 = 9'h001;
    localparam logic [8:0] P_OP = 9'h002;
    localparam logic [8:0] P_LO = 9'h004;
    localparam logic [8:0] P_HI = 9'h008;
    localparam logic [8:0] P_IX = 9'h010;
    localparam logic [8:0] P_IL = 9'h020;
    localparam logic [8:0] P_IH = 9'h040;
    localparam logic [8:0] P_CO = 9'h080;
    localparam logic [8:0] P_LR = 9'h100;

    typedef struct {
        logic       rdy;
        logic       rdy_b;
        logic [2:0] mode;
        logic       wr;
        logic       ci;
        logic [8:0] exp_a;
        logic [8:0] exp_b;
        logic [2:0] md;
        logic [2:0] cyc_a;
        logic [2:0] cyc_b;
    } vec_t;

    logic       CLK, R, RDY, rdy_b, WR, CI;
    logic [2:0] MODE;
    logic       s0_a, sop_a, slo_a, shi_a, six_a, sil_a, sih_a, sco_a, slr_a;
    logic       s0_b, sop_b, slo_b, shi_b, six_b, sil_b, sih_b, sco_b, slr_b;
    logic [2:0] md_a, md_b, cyc_a, cyc_b;
    logic [8:0] st_a, st_b;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    addr_mode_seq #(.CROSS_ALWAYS(1'b1), .CYC_W(3)) dut_a (
        .CLK(CLK), .R(R), .RDY(RDY), .MODE(MODE), .WR(WR), .CI(CI),
        .S0(s0_a), .SOP(sop_a), .SLO(slo_a), .SHI(shi_a), .SIX(six_a),
        .SIL(sil_a), .SIH(sih_a), .SCO(sco_a), .SLR(slr_a), .MD(md_a), .CYC(cyc_a)
    );

    addr_mode_seq #(.CROSS_ALWAYS(1'b0), .CYC_W(3)) dut_b (
        .CLK(CLK), .R(R), .RDY(rdy_b), .MODE(MODE), .WR(WR), .CI(CI),
        .S0(s0_b), .SOP(sop_b), .SLO(slo_b), .SHI(shi_b), .SIX(six_b),
        .SIL(sil_b), .SIH(sih_b), .SCO(sco_b), .SLR(slr_b), .MD(md_b), .CYC(cyc_b)
    );

    assign st_a = {slr_a, sco_a, sih_a, sil_a, six_a, shi_a, slo_a, sop_a, s0_a};
    assign st_b = {slr_b, sco_b, sih_b, sil_b, six_b, shi_b, slo_b, sop_b, s0_b};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [8:0] ea, input logic [8:0] eb,
                             input logic [2:0] md, input logic [2:0] ca, input logic [2:0] cb);
        check("state_a", idx, 32'(st_a), 32'(ea));
        check("state_b", idx, 32'(st_b), 32'(eb));
        check("md_a", idx, 32'(md_a), 32'(md));
        check("md_b", idx, 32'(md_b), 32'(md));
        check("cyc_a", idx, 32'(cyc_a), 32'(ca));
        check("cyc_b", idx, 32'(cyc_b), 32'(cb));
        check("onehot_a", idx, 32'($onehot(st_a)), 32'd1);
        check("onehot_b", idx, 32'($onehot(st_b)), 32'd1);
    endtask

    task automatic add2(input logic r, input logic rb, input logic [2:0] m, input logic w,
                        input logic c, input logic [8:0] ea, input logic [8:0] eb,
                        input logic [2:0] md, input logic [2:0] ca, input logic [2:0] cb);
        vec_t v;
        v.rdy = r;  v.rdy_b = rb; v.mode = m; v.wr = w; v.ci = c;
        v.exp_a = ea; v.exp_b = eb; v.md = md; v.cyc_a = ca; v.cyc_b = cb;
        vecs.push_back(v);
    endtask

    task automatic add(input logic r, input logic [2:0] m, input logic w, input logic c,
                       input logic [8:0] e, input logic [2:0] md, input logic [2:0] cy);
        add2(r, r, m, w, c, e, e, md, cy, cy);
    endtask

    initial begin
        // ABS after reset
        add(1, 4, 0, 0, P_OP, 0, 0);
        add(1, 4, 0, 0, P_LO, 4, 1);
        add(1, 4, 0, 0, P_HI, 4, 2);
        add(1, 4, 0, 0, P_LR, 4, 3);
        add(1, 5, 0, 0, P_OP, 4, 0);
        // ABSX with carry
        add(1, 5, 0, 0, P_LO, 5, 1);
        add(1, 5, 0, 0, P_HI, 5, 2);
        add(1, 5, 0, 1, P_CO, 5, 3);
        add(1, 5, 0, 0, P_LR, 5, 4);
        add(1, 5, 0, 0, P_OP, 5, 0);
        // ABSX without carry
        add(1, 5, 0, 0, P_LO, 5, 1);
        add(1, 5, 0, 0, P_HI, 5, 2);
        add(1, 5, 0, 0, P_LR, 5, 3);
        add(1, 5, 1, 0, P_OP, 5, 0);
        // ABSX write, no carry: forced fix only on instance a; b stalls once to realign
        add(1, 5, 1, 0, P_LO, 5, 1);
        add(1, 5, 1, 0, P_HI, 5, 2);
        add2(1, 1, 5, 0, 0, P_CO, P_LR, 5, 3, 3);
        add2(1, 0, 5, 0, 0, P_LR, P_LR, 5, 4, 3);
        add(1, 6, 0, 0, P_OP, 5, 0);
        // INDY with 3-cycle stall in SIL, then carry in SIH
        add(1, 6, 0, 0, P_LO, 6, 1);
        add(1, 6, 0, 0, P_IL, 6, 2);
        add(0, 3, 0, 1, P_IL, 6, 2);
        add(0, 3, 0, 1, P_IL, 6, 2);
        add(0, 3, 0, 1, P_IL, 6, 2);
        add(1, 3, 0, 0, P_IH, 6, 3);
        add(1, 3, 0, 1, P_CO, 6, 4);
        add(1, 7, 0, 0, P_LR, 6, 5);
        add(1, 7, 0, 0, P_OP, 6, 0);
        // INDX then IMP back-to-back; CI outside SHI/SIH ignored
        add(1, 7, 0, 0, P_LO, 7, 1);
        add(1, 7, 0, 1, P_IX, 7, 2);
        add(1, 7, 0, 1, P_IL, 7, 3);
        add(1, 7, 0, 1, P_IH, 7, 4);
        add(1, 7, 0, 1, P_LR, 7, 5);
        add(1, 0, 0, 0, P_OP, 7, 0);
        add(1, 0, 0, 0, P_LR, 0, 1);
        add(1, 3, 0, 0, P_OP, 0, 0);
        // ZPX, stall in SOP re-sampling MODE, ZP, IMM
        add(1, 3, 0, 0, P_LO, 3, 1);
        add(1, 3, 0, 0, P_IX, 3, 2);
        add(1, 3, 0, 0, P_LR, 3, 3);
        add(1, 3, 0, 0, P_OP, 3, 0);
        add(0, 2, 0, 0, P_OP, 3, 0);
        add(1, 2, 0, 0, P_LO, 2, 1);
        add(1, 2, 0, 0, P_LR, 2, 2);
        add(1, 1, 0, 0, P_OP, 2, 0);
        add(1, 1, 0, 0, P_LR, 1, 1);
        add(1, 6, 0, 0, P_OP, 1, 0);
        // INDY without carry, then stop in SIH for the reset sequence
        add(1, 6, 0, 0, P_LO, 6, 1);
        add(1, 6, 0, 0, P_IL, 6, 2);
        add(1, 6, 0, 0, P_IH, 6, 3);
        add(1, 6, 0, 0, P_LR, 6, 4);
        add(1, 6, 0, 0, P_OP, 6, 0);
        add(1, 6, 0, 0, P_LO, 6, 1);
        add(1, 6, 0, 0, P_IL, 6, 2);
        add(1, 6, 0, 0, P_IH, 6, 3);

        R = 1'b0; RDY = 1'b0; rdy_b = 1'b0; MODE = 3'd0; WR = 1'b0; CI = 1'b0;
        #12;
        check_all(-1, P_S0, P_S0, 0, 0, 0);
        R = 1'b1;

        foreach (vecs[i]) begin
            RDY = vecs[i].rdy; rdy_b = vecs[i].rdy_b;
            MODE = vecs[i].mode; WR = vecs[i].wr; CI = vecs[i].ci;
            @(posedge CLK);
            #1;
            check_all(i, vecs[i].exp_a, vecs[i].exp_b, vecs[i].md, vecs[i].cyc_a,
                      vecs[i].cyc_b);
        end

        // Asynchronous reset between edges while in SIH
        #3 R = 1'b0;
        #1 check_all(100, P_S0, P_S0, 0, 0, 0);
        #2 R = 1'b1;
        MODE = 3'd4; WR = 1'b0; CI = 1'b0; RDY = 1'b1; rdy_b = 1'b1;
        @(posedge CLK);
        #1 check_all(101, P_OP, P_OP, 0, 0, 0);
        @(posedge CLK);
        #1 check_all(102, P_LO, P_LO, 4, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
